jzjpcc_decode_pipeline: RTL and testbench

Parametrised decode-to-execute stage register for the pipelined core, successor to the basic decode stage. It adds stall/hold, flush-to-bubble, a valid bit, and operand bypassing from the memory and writeback stages. It also detects load-use hazards, inserts one bubble per hazard, and keeps a saturating bubble counter. It sits between fetch/register-file read and the execute stage.

---
 rtl/jzjpcc_decode_pipeline.sv | 186 ++++++++++++++++++
 tb/tb_jzjpcc_decode_pipeline.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_decode_pipeline.sv
// Decode-to-execute stage register with operand bypassing, stall/flush control,
// load-use hazard detection and a saturating count of inserted bubbles.
module jzjpcc_decode_pipeline #(
  parameter int                PC_MAX_B = 15,
  parameter int                CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int                CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,

  input  logic [31:2]         instruction_decode,
  input  logic [PC_MAX_B:2]   currentPC_decode,
  input  logic                valid_decode,
  input  logic [31:0]         immediate_decode,
  input  logic [CTRL_W-1:0]   control_decode,
  input  logic                rdWriteEnable_decode,
  input  logic                memRead_decode,
  output logic [4:0]          rs1Addr_decode,
  output logic [4:0]          rs2Addr_decode,
  input  logic [31:0]         rs1_decode,
  input  logic [31:0]         rs2_decode,

  input  logic [4:0]          rdAddr_memory,
  input  logic                rdWriteEnable_memory,
  input  logic [31:0]         result_memory,
  input  logic [4:0]          rdAddr_writeback,
  input  logic                rdWriteEnable_writeback,
  input  logic [31:0]         rdData_writeback,

  input  logic                stall_execute,
  input  logic                flush_execute,
  output logic                loadUseStall_decode,

  output logic [31:0]         immediate_execute,
  output logic [31:0]         rs1_execute,
  output logic [31:0]         rs2_execute,
  output logic [PC_MAX_B:2]   currentPC_execute,
  output logic [4:0]          rdAddr_execute,
  output logic [CTRL_W-1:0]   control_execute,
  output logic                rdWriteEnable_execute,
  output logic                memRead_execute,
  output logic                valid_execute,
  output logic [CNT_W-1:0]    bubbleCount
);

  logic [31:0]       imm_q, imm_d;
  logic [31:0]       rs1_q, rs1_d;
  logic [31:0]       rs2_q, rs2_d;
  logic [PC_MAX_B:2] pc_q, pc_d;
  logic [4:0]        rdAddr_q, rdAddr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              rdWe_q, rdWe_d;
  logic              memRead_q, memRead_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;

  logic [4:0]        rdAddrDecode;
  logic [31:0]       rs1Bypassed;
  logic [31:0]       rs2Bypassed;
  logic              loadUse;
  logic              loadSlot;
  logic              injectBubble;
  logic              unusedInstrBits;

  assign rs1Addr_decode  = instruction_decode[19:15];
  assign rs2Addr_decode  = instruction_decode[24:20];
  assign rdAddrDecode    = instruction_decode[11:7];
  assign unusedInstrBits = ^{instruction_decode[31:25], instruction_decode[14:12],
                             instruction_decode[6:2]};

  // x0 is hardwired, so it never takes a bypass; the younger memory stage wins over writeback.
  function automatic logic [31:0] selectOperand(
    input logic [4:0]  addr,
    input logic [31:0] rfData,
    input logic        memWe,
    input logic [4:0]  memRd,
    input logic [31:0] memData,
    input logic        wbWe,
    input logic [4:0]  wbRd,
    input logic [31:0] wbData
  );
    logic [31:0] sel;
    sel = rfData;
    if (addr != 5'd0) begin
      if (memWe && (memRd == addr)) begin
        sel = memData;
      end else if (wbWe && (wbRd == addr)) begin
        sel = wbData;
      end
    end
    return sel;
  endfunction

  always_comb begin
    rs1Bypassed = selectOperand(rs1Addr_decode, rs1_decode,
                                rdWriteEnable_memory, rdAddr_memory, result_memory,
                                rdWriteEnable_writeback, rdAddr_writeback, rdData_writeback);
    rs2Bypassed = selectOperand(rs2Addr_decode, rs2_decode,
                                rdWriteEnable_memory, rdAddr_memory, result_memory,
                                rdWriteEnable_writeback, rdAddr_writeback, rdData_writeback);
  end

  // Conservative: rs2 is compared even for instructions that carry an immediate there.
  assign loadUse = valid_q && memRead_q && (rdAddr_q != 5'd0) && valid_decode &&
                   ((rdAddr_q == rs1Addr_decode) || (rdAddr_q == rs2Addr_decode));
  assign loadUseStall_decode = loadUse && !stall_execute && !flush_execute;

  assign loadSlot     = flush_execute || !stall_execute;
  assign injectBubble = flush_execute || loadUseStall_decode;

  always_comb begin
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    pc_d        = pc_q;
    rdAddr_d    = rdAddr_q;
    ctrl_d      = ctrl_q;
    rdWe_d      = rdWe_q;
    memRead_d   = memRead_q;
    valid_d     = valid_q;
    bubbleCnt_d = bubbleCnt_q;

    if (loadSlot) begin
      imm_d = immediate_decode;
      rs1_d = rs1Bypassed;
      rs2_d = rs2Bypassed;
      pc_d  = currentPC_decode;
      if (injectBubble || !valid_decode) begin
        rdAddr_d  = 5'd0;
        ctrl_d    = NOP_CTRL;
        rdWe_d    = 1'b0;
        memRead_d = 1'b0;
        valid_d   = 1'b0;
      end else begin
        rdAddr_d  = rdAddrDecode;
        ctrl_d    = control_decode;
        rdWe_d    = rdWriteEnable_decode;
        memRead_d = memRead_decode;
        valid_d   = 1'b1;
      end
    end

    if (injectBubble && (bubbleCnt_q != {CNT_W{1'b1}})) begin
      bubbleCnt_d = bubbleCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      pc_q        <= '0;
      rdAddr_q    <= '0;
      ctrl_q      <= NOP_CTRL;
      rdWe_q      <= 1'b0;
      memRead_q   <= 1'b0;
      valid_q     <= 1'b0;
      bubbleCnt_q <= '0;
    end else begin
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      pc_q        <= pc_d;
      rdAddr_q    <= rdAddr_d;
      ctrl_q      <= ctrl_d;
      rdWe_q      <= rdWe_d;
      memRead_q   <= memRead_d;
      valid_q     <= valid_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign immediate_execute     = imm_q;
  assign rs1_execute           = rs1_q;
  assign rs2_execute           = rs2_q;
  assign currentPC_execute     = pc_q;
  assign rdAddr_execute        = rdAddr_q;
  assign control_execute       = ctrl_q;
  assign rdWriteEnable_execute = rdWe_q;
  assign memRead_execute       = memRead_q;
  assign valid_execute         = valid_q;
  assign bubbleCount           = bubbleCnt_q;

endmodule

// File: tb/tb_jzjpcc_decode_pipeline.sv
// Self-checking bench for jzjpcc_decode_pipeline: a behavioural model of the execute slot
// checked every cycle, plus hand-computed literal expectations for key scenarios.
module tb_jzjpcc_decode_pipeline;

  localparam int         PCB  = 15;
  localparam int         CW   = 8;
  localparam int         CNTW = 4;
  localparam logic [7:0] NOP  = 8'hA5;
  localparam int         SAT  = 15;

  logic         clock;
  logic         reset;
  logic [31:0]  instrFull;
  logic [31:2]  instrDecode;
  logic [PCB:2] pcDecode;
  logic         validDecode;
  logic [31:0]  immDecode;
  logic [CW-1:0] ctrlDecode;
  logic         rdWeDecode;
  logic         memReadDecode;
  logic [4:0]   rs1AddrDecode;
  logic [4:0]   rs2AddrDecode;
  logic [31:0]  rf1;
  logic [31:0]  rf2;
  logic [4:0]   memRd;
  logic         memWe;
  logic [31:0]  memResult;
  logic [4:0]   wbRd;
  logic         wbWe;
  logic [31:0]  wbData;
  logic         stall;
  logic         flush;
  logic         loadUseStall;
  logic [31:0]  immExecute;
  logic [31:0]  rs1Execute;
  logic [31:0]  rs2Execute;
  logic [PCB:2] pcExecute;
  logic [4:0]   rdAddrExecute;
  logic [CW-1:0] ctrlExecute;
  logic         rdWeExecute;
  logic         memReadExecute;
  logic         validExecute;
  logic [CNTW-1:0] bubbleCount;

  int compared;
  int mismatched;
  bit checkEn;

  // Expected execute-slot contents
  bit           mValid;
  bit           mRdWe;
  bit           mMemRead;
  int           mRd;
  int           mCtrl;
  logic [31:0]  mImm;
  logic [31:0]  mRs1;
  logic [31:0]  mRs2;
  logic [PCB:2] mPc;
  int           mCount;

  assign instrDecode = instrFull[31:2];

  jzjpcc_decode_pipeline #(
    .PC_MAX_B(PCB), .CTRL_W(CW), .NOP_CTRL(NOP), .CNT_W(CNTW)
  ) dut (
    .clock(clock), .reset(reset),
    .instruction_decode(instrDecode), .currentPC_decode(pcDecode),
    .valid_decode(validDecode), .immediate_decode(immDecode),
    .control_decode(ctrlDecode), .rdWriteEnable_decode(rdWeDecode),
    .memRead_decode(memReadDecode),
    .rs1Addr_decode(rs1AddrDecode), .rs2Addr_decode(rs2AddrDecode),
    .rs1_decode(rf1), .rs2_decode(rf2),
    .rdAddr_memory(memRd), .rdWriteEnable_memory(memWe), .result_memory(memResult),
    .rdAddr_writeback(wbRd), .rdWriteEnable_writeback(wbWe), .rdData_writeback(wbData),
    .stall_execute(stall), .flush_execute(flush),
    .loadUseStall_decode(loadUseStall),
    .immediate_execute(immExecute), .rs1_execute(rs1Execute), .rs2_execute(rs2Execute),
    .currentPC_execute(pcExecute), .rdAddr_execute(rdAddrExecute),
    .control_execute(ctrlExecute), .rdWriteEnable_execute(rdWeExecute),
    .memRead_execute(memReadExecute), .valid_execute(validExecute),
    .bubbleCount(bubbleCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [6:0] op);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  // Value an instruction should see for a source register given the in-flight writers
  function automatic logic [31:0] modelOperand(input int addr, input logic [31:0] rfValue);
    if (addr == 0) return rfValue;
    if (memWe && int'(memRd) == addr) return memResult;
    if (wbWe && int'(wbRd) == addr) return wbData;
    return rfValue;
  endfunction

  function automatic bit modelLoadUse();
    int src1;
    int src2;
    src1 = int'(instrFull[19:15]);
    src2 = int'(instrFull[24:20]);
    if (stall || flush) return 1'b0;
    return mValid && mMemRead && mRd != 0 && validDecode && (mRd == src1 || mRd == src2);
  endfunction

  task automatic modelLoadFromDecode();
    mImm = immDecode;
    mRs1 = modelOperand(int'(instrFull[19:15]), rf1);
    mRs2 = modelOperand(int'(instrFull[24:20]), rf2);
    mPc  = pcDecode;
  endtask

  task automatic modelBubble();
    mValid = 0; mRdWe = 0; mMemRead = 0; mRd = 0; mCtrl = int'(NOP);
    if (mCount < SAT) mCount++;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      mValid = 0; mRdWe = 0; mMemRead = 0; mRd = 0; mCtrl = int'(NOP);
      mImm = 0; mRs1 = 0; mRs2 = 0; mPc = 0; mCount = 0;
    end else if (flush) begin
      modelLoadFromDecode();
      modelBubble();
    end else if (stall) begin
      mCount = mCount;
    end else if (modelLoadUse()) begin
      modelLoadFromDecode();
      modelBubble();
    end else begin
      modelLoadFromDecode();
      mValid   = validDecode;
      mRdWe    = validDecode && rdWeDecode;
      mMemRead = validDecode && memReadDecode;
      mRd      = validDecode ? int'(instrFull[11:7]) : 0;
      mCtrl    = validDecode ? int'(ctrlDecode) : int'(NOP);
    end
  end

  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("valid_execute", 32'(validExecute), 32'(mValid));
      checkOutput("rdWriteEnable_execute", 32'(rdWeExecute), 32'(mRdWe));
      checkOutput("memRead_execute", 32'(memReadExecute), 32'(mMemRead));
      checkOutput("rdAddr_execute", 32'(rdAddrExecute), 32'(mRd));
      checkOutput("control_execute", 32'(ctrlExecute), 32'(mCtrl));
      checkOutput("immediate_execute", immExecute, mImm);
      checkOutput("rs1_execute", rs1Execute, mRs1);
      checkOutput("rs2_execute", rs2Execute, mRs2);
      checkOutput("currentPC_execute", 32'(pcExecute), 32'(mPc));
      checkOutput("bubbleCount", 32'(bubbleCount), 32'(mCount));
      checkOutput("loadUseStall_decode", 32'(loadUseStall), 32'(modelLoadUse()));
      checkOutput("rs1Addr_decode", 32'(rs1AddrDecode), 32'(instrFull[19:15]));
      checkOutput("rs2Addr_decode", 32'(rs2AddrDecode), 32'(instrFull[24:20]));
    end
  end

  task automatic applyStimulus(input logic [31:0] instr, input logic valid,
                               input logic [31:0] imm, input logic [7:0] ctrl,
                               input logic rdWe, input logic memRead,
                               input logic [PCB:2] pc,
                               input logic [31:0] reg1, input logic [31:0] reg2);
    instrFull = instr; validDecode = valid; immDecode = imm; ctrlDecode = ctrl;
    rdWeDecode = rdWe; memReadDecode = memRead; pcDecode = pc; rf1 = reg1; rf2 = reg2;
  endtask

  task automatic setBypass(input logic mWe, input logic [4:0] mRdIn, input logic [31:0] mRes,
                           input logic wWe, input logic [4:0] wRdIn, input logic [31:0] wDat);
    memWe = mWe; memRd = mRdIn; memResult = mRes;
    wbWe = wWe; wbRd = wRdIn; wbData = wDat;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    checkEn = 0;

    // Reset with every input driven nonzero
    reset = 1; stall = 1; flush = 1;
    applyStimulus(mk(5'd9, 5'd3, 5'd4, 7'h03), 1, 32'hFFFF_0001, 8'h3C, 1, 1, 14'h1ABC,
                  32'h1357, 32'h2468);
    setBypass(1, 5'd3, 32'hDEAD, 1, 5'd4, 32'hBEEF);
    nextCycle();
    checkEn = 1;
    checkOutput("reset valid", 32'(validExecute), 32'd0);
    checkOutput("reset rdAddr", 32'(rdAddrExecute), 32'd0);
    checkOutput("reset control", 32'(ctrlExecute), 32'hA5);
    checkOutput("reset bubbleCount", 32'(bubbleCount), 32'd0);

    // addi x5,x0,7
    reset = 0; stall = 0; flush = 0;
    setBypass(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    applyStimulus(mk(5'd5, 5'd0, 5'd7, 7'h13), 1, 32'd7, 8'h21, 1, 0, 14'h0010,
                  32'h1234, 32'h0);
    nextCycle();
    checkOutput("addi rdAddr", 32'(rdAddrExecute), 32'd5);
    checkOutput("addi valid", 32'(validExecute), 32'd1);
    checkOutput("addi immediate", immExecute, 32'd7);
    checkOutput("addi rs1", rs1Execute, 32'h1234);

    // Bypass priority on rs1 = x3
    applyStimulus(mk(5'd7, 5'd3, 5'd9, 7'h33), 1, 32'd0, 8'h22, 1, 0, 14'h0011,
                  32'h1111, 32'h2222);
    setBypass(1, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB);
    nextCycle();
    checkOutput("bypass memory", rs1Execute, 32'hAAAA);
    checkOutput("bypass rs2 regfile", rs2Execute, 32'h2222);
    setBypass(0, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB);
    nextCycle();
    checkOutput("bypass writeback", rs1Execute, 32'hBBBB);
    applyStimulus(mk(5'd7, 5'd0, 5'd9, 7'h33), 1, 32'd0, 8'h22, 1, 0, 14'h0012,
                  32'h1111, 32'h2222);
    setBypass(1, 5'd0, 32'hAAAA, 1, 5'd0, 32'hBBBB);
    nextCycle();
    checkOutput("bypass x0", rs1Execute, 32'h1111);
    applyStimulus(mk(5'd7, 5'd3, 5'd9, 7'h33), 1, 32'd0, 8'h22, 1, 0, 14'h0013,
                  32'h1111, 32'h2222);
    setBypass(1, 5'd9, 32'hCCCC, 1, 5'd3, 32'hBBBB);
    nextCycle();
    checkOutput("bypass split rs1", rs1Execute, 32'hBBBB);
    checkOutput("bypass split rs2", rs2Execute, 32'hCCCC);

    // lw x4 followed by dependent add x6,x4,x1
    setBypass(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    applyStimulus(mk(5'd4, 5'd2, 5'd0, 7'h03), 1, 32'd0, 8'h40, 1, 1, 14'h0020,
                  32'h100, 32'h0);
    nextCycle();
    applyStimulus(mk(5'd6, 5'd4, 5'd1, 7'h33), 1, 32'd0, 8'h22, 1, 0, 14'h0021,
                  32'h9999, 32'h7);
    #1;
    checkOutput("load-use raised", 32'(loadUseStall), 32'd1);
    nextCycle();
    checkOutput("load-use bubble valid", 32'(validExecute), 32'd0);
    checkOutput("load-use bubbleCount", 32'(bubbleCount), 32'd1);
    setBypass(1, 5'd4, 32'h55, 0, 5'd0, 32'd0);
    #1;
    checkOutput("load-use cleared", 32'(loadUseStall), 32'd0);
    nextCycle();
    checkOutput("dependent add rs1", rs1Execute, 32'h55);
    checkOutput("dependent add rdAddr", 32'(rdAddrExecute), 32'd6);

    // Hold for three cycles while decode keeps changing
    setBypass(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(5'(10 + i), 5'd6, 5'd6, 7'h33), 1, 32'(i + 100), 8'(i), 1, 0,
                    14'(i + 40), 32'(i), 32'(i * 3));
      nextCycle();
    end
    checkOutput("stall rdAddr held", 32'(rdAddrExecute), 32'd6);
    checkOutput("stall rs1 held", rs1Execute, 32'h55);
    checkOutput("stall bubbleCount held", 32'(bubbleCount), 32'd1);

    // Flush wins over stall
    flush = 1;
    nextCycle();
    checkOutput("flush+stall valid", 32'(validExecute), 32'd0);
    checkOutput("flush+stall bubbleCount", 32'(bubbleCount), 32'd2);

    // Load-use suppressed by flush, then by stall; valid_decode=0 is not counted
    flush = 0; stall = 0;
    applyStimulus(mk(5'd8, 5'd1, 5'd0, 7'h03), 1, 32'd4, 8'h40, 1, 1, 14'h0030,
                  32'h10, 32'h0);
    nextCycle();
    applyStimulus(mk(5'd9, 5'd1, 5'd8, 7'h33), 1, 32'd0, 8'h22, 1, 0, 14'h0031,
                  32'h20, 32'h30);
    flush = 1;
    #1;
    checkOutput("load-use masked by flush", 32'(loadUseStall), 32'd0);
    flush = 0; stall = 1;
    #1;
    checkOutput("load-use masked by stall", 32'(loadUseStall), 32'd0);
    stall = 0;
    applyStimulus(mk(5'd9, 5'd1, 5'd8, 7'h33), 0, 32'd0, 8'h22, 1, 0, 14'h0032,
                  32'h20, 32'h30);
    nextCycle();
    checkOutput("invalid decode bubbleCount", 32'(bubbleCount), 32'd2);
    checkOutput("invalid decode control", 32'(ctrlExecute), 32'hA5);

    // Saturate the bubble counter
    flush = 1;
    for (int i = 0; i < 20; i++) nextCycle();
    checkOutput("bubbleCount saturated", 32'(bubbleCount), 32'd15);

    // Reset asserted in the middle of a stall
    flush = 0;
    applyStimulus(mk(5'd12, 5'd2, 5'd3, 7'h33), 1, 32'h77, 8'h11, 1, 0, 14'h0050,
                  32'h5, 32'h6);
    nextCycle();
    stall = 1;
    nextCycle();
    reset = 1;
    nextCycle();
    checkOutput("mid-stall reset valid", 32'(validExecute), 32'd0);
    checkOutput("mid-stall reset rdAddr", 32'(rdAddrExecute), 32'd0);
    checkOutput("mid-stall reset immediate", immExecute, 32'd0);
    checkOutput("mid-stall reset bubbleCount", 32'(bubbleCount), 32'd0);
    reset = 0; stall = 0;
    nextCycle();
    nextCycle();

    checkEn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
